// File: rtl/pipelined_adder.sv
// WIDTH-bit ripple-carry adder split into STAGES registered carry-chained slices with a valid/ready handshake.
// Optional signed-overflow output Ovf is enabled by defining ADDER_OVERFLOW_EN.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CHUNK = WIDTH / STAGES;

    logic              adv;
    logic [WIDTH-1:0]  a_r  [STAGES];
    logic [WIDTH-1:0]  b_r  [STAGES];
    logic [WIDTH-1:0]  s_r  [STAGES];
    logic [STAGES-1:0] c_r;
    logic [STAGES-1:0] v_r;

    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nx;
    logic [STAGES-1:0] v_in;
    logic [CHUNK:0]    t;

    // The whole pipeline advances as one unit; bubbles are never squeezed out.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        a_in = '{default: '0};
        b_in = '{default: '0};
        s_in = '{default: '0};
        c_in = '0;
        v_in = '0;
        a_in[0] = A;
        b_in[0] = B;
        c_in[0] = Cin;
        v_in[0] = in_valid && adv;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_in[k] = a_r[k-1];
            b_in[k] = b_r[k-1];
            s_in[k] = s_r[k-1];
            c_in[k] = c_r[k-1];
            v_in[k] = v_r[k-1];
        end
    end

    // Stage k adds its own slice and splices it into the partial sum from below.
    always_comb begin
        t    = '0;
        s_nx = '{default: '0};
        c_nx = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            t = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
              + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_in[k]};
            s_nx[k] = s_in[k];
            s_nx[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
            c_nx[k] = t[CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_r <= '0;
            c_r <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
        end else if (adv) begin
            v_r <= v_in;
            c_r <= c_nx;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_r[k] <= a_in[k];
                b_r[k] <= b_in[k];
                s_r[k] <= s_nx[k];
            end
        end
    end

    assign out_valid = v_r[STAGES-1];
    assign Sum       = s_r[STAGES-1];
    assign Cout      = c_r[STAGES-1];

`ifdef ADDER_OVERFLOW_EN
    logic ovf_nx;
    logic ovf_r;

    // Operand MSBs reaching the last stage are the delayed copies of A/B.
    always_comb begin
        ovf_nx = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
              && (s_nx[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (adv) begin
            ovf_r <= ovf_nx;
        end
    end

    assign Ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed testbench for pipelined_adder: 8-bit/2-stage instance plus a 1-bit/1-stage full-adder instance.
// Overflow checks are compiled in when ADDER_OVERFLOW_EN is defined.
module tb_pipelined_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       Cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] Sum;
    logic       Cout;

    logic iv1 = 1'b0, ir1, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, ov1, or1 = 1'b1, s1, co1;

`ifdef ADDER_OVERFLOW_EN
    logic Ovf;
    logic ovf1;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] st_a [4] = '{8'h10, 8'hF0, 8'h80, 8'h01};
    logic [7:0] st_b [4] = '{8'h20, 8'h0F, 8'h80, 8'h01};
    logic       st_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] st_s [4] = '{8'h30, 8'h00, 8'h00, 8'h03};
    logic       st_co[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    // stall scenario: 01+02+0=003, 33+44+1=078, C0+50+0=110, 7F+7F+1=0FF
    logic [7:0] sl_a [4] = '{8'h01, 8'h33, 8'hC0, 8'h7F};
    logic [7:0] sl_b [4] = '{8'h02, 8'h44, 8'h50, 8'h7F};
    logic       sl_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] sl_s [4] = '{8'h03, 8'h78, 8'h10, 8'hFF};
    logic       sl_co[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    // full-adder truth table {cout,sum}, indexed by {a,b,cin}
    logic [1:0] ft [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout)
`ifdef ADDER_OVERFLOW_EN
        , .Ovf(Ovf)
`endif
    );

    pipelined_adder #(.WIDTH(1), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .A(a1), .B(b1), .Cin(c1), .out_valid(ov1), .out_ready(or1),
        .Sum(s1), .Cout(co1)
`ifdef ADDER_OVERFLOW_EN
        , .Ovf(ovf1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [7:0] es, input logic ec);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s out_valid: got %b expected 1", name, out_valid);
        end
        vectors++;
        if (Sum !== es) begin
            miscompares++;
            $display("FAIL %s Sum: got %h expected %h", name, Sum, es);
        end
        vectors++;
        if (Cout !== ec) begin
            miscompares++;
            $display("FAIL %s Cout: got %b expected %b", name, Cout, ec);
        end
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s out_valid: got %b expected 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check_idle("reset");
        vectors++;
        if (Sum !== 8'h00 || Cout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset data: got %h/%b expected 00/0", Sum, Cout);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset in_ready: got %b expected 1", in_ready);
        end
`ifdef ADDER_OVERFLOW_EN
        vectors++;
        if (Ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset Ovf: got %b expected 0", Ovf);
        end
`endif
    endtask

    task automatic test_carry_boundary();
        A = 8'hFF; B = 8'h01; Cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_idle("carry_latency1");
        step();
        check_out("carry_boundary", 8'h00, 1'b1);
        step();
        check_idle("carry_drain");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; A = st_a[i]; B = st_b[i]; Cin = st_c[i];
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) check_out($sformatf("stream%0d", i - 1), st_s[i-1], st_co[i-1]);
        end
        in_valid = 1'b0;
        step();
        check_idle("stream_drain");
    endtask

    task automatic test_back_to_back_stall();
        out_ready = 1'b1;
        in_valid = 1'b1; A = sl_a[0]; B = sl_b[0]; Cin = sl_c[0];
        step();
        A = sl_a[1]; B = sl_b[1]; Cin = sl_c[1];
        step();
        check_out("stall_first", sl_s[0], sl_co[0]);
        out_ready = 1'b0;
        A = sl_a[2]; B = sl_b[2]; Cin = sl_c[2];
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_in_ready%0d: got %b expected 0", i, in_ready);
            end
            step();
            check_out($sformatf("stall_hold%0d", i), sl_s[0], sl_co[0]);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
        step();
        check_out("release1", sl_s[1], sl_co[1]);
        A = sl_a[3]; B = sl_b[3]; Cin = sl_c[3];
        step();
        check_out("release2", sl_s[2], sl_co[2]);
        in_valid = 1'b0;
        step();
        check_out("release3", sl_s[3], sl_co[3]);
        step();
        check_idle("release_drain");
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        in_valid = 1'b1; A = 8'hF0; B = 8'h20; Cin = 1'b0;
        step();
        A = 8'h11; B = 8'h22; Cin = 1'b1;
        step();
        check_out("pre_reset", 8'h10, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midreset");
        vectors++;
        if (Sum !== 8'h00 || Cout !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset data: got %h/%b expected 00/0", Sum, Cout);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("post_reset%0d", i));
        end
    endtask

`ifdef ADDER_OVERFLOW_EN
    task automatic ovf_case(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] es, input logic ec, input logic eo);
        in_valid = 1'b1; A = a; B = b; Cin = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        check_out(name, es, ec);
        vectors++;
        if (Ovf !== eo) begin
            miscompares++;
            $display("FAIL %s Ovf: got %b expected %b", name, Ovf, eo);
        end
        step();
    endtask

    task automatic test_overflow();
        ovf_case("ovf_pos", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        ovf_case("ovf_neg", 8'h80, 8'hFF, 8'h7F, 1'b1, 1'b1);
        ovf_case("ovf_none", 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_full_adder();
        logic [2:0] v;
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            e = ft[i];
            a1 = v[2]; b1 = v[1]; c1 = v[0]; iv1 = 1'b1;
            step();
            vectors++;
            if (ov1 !== 1'b1 || {co1, s1} !== e) begin
                miscompares++;
                $display("FAIL fa%0d: got valid=%b cout/sum=%b%b expected valid=1 %b", i, ov1, co1, s1, e);
            end
        end
        iv1 = 1'b0;
        step();
        vectors++;
        if (ov1 !== 1'b0) begin
            miscompares++;
            $display("FAIL fa_drain out_valid: got %b expected 0", ov1);
        end
    endtask

    initial begin
        test_reset();
        test_carry_boundary();
        test_stream();
        test_back_to_back_stall();
        test_reset_midflight();
`ifdef ADDER_OVERFLOW_EN
        test_overflow();
`endif
        test_full_adder();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
